// File: rtl/i4004_bus_agent.sv
// I4004 pad-level bus agent: follows the 8-phase cycle from SYNC/CLK2, captures the address,
// serves {OPR,OPA} from a response FIFO in M1/M2. Define I4004_AGENT_MON_EN for the X2 monitor.
module i4004_bus_agent #(
  parameter int unsigned DW       = 4,
  parameter int unsigned ADDR_NIB = 3,
  parameter int unsigned CM_CH    = 4,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                         sysclk,
  input  logic                         reset_n,
  input  logic                         clk2_pad,
  input  logic                         poc_pad,
  input  logic                         sync_pad,
  input  logic                         cmrom_pad,
  input  logic [CM_CH-1:0]             cmram_pad,
  input  logic [DW-1:0]                data_in,
  output logic [DW-1:0]                data_out,
  output logic                         data_oe,
  input  logic                         rsp_valid,
  output logic                         rsp_ready,
  input  logic [2*DW-1:0]              rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         addr_valid,
  output logic [ADDR_NIB*DW-1:0]       addr_out,
  output logic [CM_CH:0]               cm_sel,
  output logic                         x2_valid,
  output logic [DW-1:0]                x2_data,
  output logic                         cycle_err,
  output logic                         underrun
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    StIdle, StA1, StA2, StA3, StM1, StM2, StX1, StX2, StX3
  } state_e;

  state_e                r_state, w_state_d;
  logic                  r_clk2_q;
  logic                  w_stb, w_adv, w_cyc_err;
  logic                  w_enter_m1, w_hit_d, w_empty_d;
  logic                  r_rom_hit, r_fetch_empty;
  logic                  r_oe, w_oe_d;
  logic [DW-1:0]         r_dout, w_dout_d;
  logic                  r_addr_valid;
  logic [ADDR_NIB*DW-1:0] r_addr;
  logic [CM_CH:0]        r_cm_sel;
  logic                  r_cycle_err, r_underrun;

  logic [2*DW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_push, w_pop, w_fifo_empty;
  logic [2*DW-1:0]       w_head;

  assign w_stb        = clk2_pad & ~r_clk2_q;
  // Normal sequential advance: strobe without SYNC and not held by power-on clear.
  assign w_adv        = w_stb & ~sync_pad & ~poc_pad;
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rptr];
  assign rsp_ready    = (r_count < CW'(DEPTH));
  assign w_push       = rsp_valid & rsp_ready;
  assign w_pop        = w_adv & (r_state == StM2) & r_rom_hit & ~r_fetch_empty;
  assign w_enter_m1   = w_adv & (r_state == StA3);
  assign w_hit_d      = w_enter_m1 ? cmrom_pad : r_rom_hit;
  assign w_empty_d    = w_enter_m1 ? w_fifo_empty : r_fetch_empty;

  always_comb begin
    w_state_d = r_state;
    w_cyc_err = 1'b0;
    if (poc_pad) begin
      w_state_d = StIdle;
    end else if (w_stb) begin
      case (r_state)
        StA1:    w_state_d = StA2;
        StA2:    w_state_d = StA3;
        StA3:    w_state_d = StM1;
        StM1:    w_state_d = StM2;
        StM2:    w_state_d = StX1;
        StX1:    w_state_d = StX2;
        StX2:    w_state_d = StX3;
        StX3:    w_state_d = StIdle;
        default: w_state_d = r_state;
      endcase
      if (sync_pad) begin
        w_state_d = StA1;
        w_cyc_err = (r_state != StIdle) && (r_state != StX3);
      end else begin
        w_cyc_err = (r_state == StX3);
      end
    end
  end

  // Pad drive is computed from the next state so it is registered yet aligned to M1/M2.
  always_comb begin
    w_oe_d   = 1'b0;
    w_dout_d = '0;
    if (w_hit_d && (w_state_d == StM1 || w_state_d == StM2)) begin
      w_oe_d = 1'b1;
      if (!w_empty_d) begin
        w_dout_d = (w_state_d == StM1) ? w_head[2*DW-1:DW] : w_head[DW-1:0];
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_clk2_q <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_clk2_q <= clk2_pad;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_oe          <= 1'b0;
      r_dout        <= '0;
      r_addr_valid  <= 1'b0;
      r_addr        <= '0;
      r_cm_sel      <= '0;
      r_rom_hit     <= 1'b0;
      r_fetch_empty <= 1'b0;
      r_cycle_err   <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_oe          <= w_oe_d;
      r_dout        <= w_dout_d;
      r_addr_valid  <= w_enter_m1;
      r_rom_hit     <= w_hit_d;
      r_fetch_empty <= w_empty_d;
      if (w_adv) begin
        case (r_state)
          StA1:    r_addr[0*DW +: DW] <= data_in;
          StA2:    r_addr[1*DW +: DW] <= data_in;
          StA3:    r_addr[2*DW +: DW] <= data_in;
          default: ;
        endcase
      end
      if (w_enter_m1) begin
        r_cm_sel <= {cmram_pad, cmrom_pad};
      end
      if (w_cyc_err) begin
        r_cycle_err <= 1'b1;
      end
      if (w_enter_m1 && cmrom_pad && w_fifo_empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= rsp_data;
    end
  end

`ifdef I4004_AGENT_MON_EN
  logic [DW-1:0] r_x2_data;
  logic          r_x2_valid;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_x2_data  <= '0;
      r_x2_valid <= 1'b0;
    end else begin
      r_x2_valid <= w_adv && (r_state == StX2);
      if (w_adv && (r_state == StX2)) begin
        r_x2_data <= data_in;
      end
    end
  end

  assign x2_data  = r_x2_data;
  assign x2_valid = r_x2_valid;
`else
  assign x2_data  = '0;
  assign x2_valid = 1'b0;
`endif

  assign data_out   = r_dout;
  assign data_oe    = r_oe;
  assign fifo_count = r_count;
  assign addr_valid = r_addr_valid;
  assign addr_out   = r_addr;
  assign cm_sel     = r_cm_sel;
  assign cycle_err  = r_cycle_err;
  assign underrun   = r_underrun;

endmodule

// File: doc/i4004_bus_agent.md
# i4004_bus_agent

- Parametrised, synthesizable bus agent for the I4004 verification environment; next generation of the pad-level bus interface.
- Tracks the 8-phase instruction cycle (A1–A3, M1, M2, X1–X3) from SYNC and the CLK2 edge, and captures the address nibbles.
- Serves opcodes to the DUT from a response FIFO during M1/M2 and monitors X2 data.
- Sits between the testbench sequencer and the DUT data pads; replaces the direct set/get pad-access functions.

## Interface
Parameters:
- DW, 4, data pad width in bits
- ADDR_NIB, 3, address nibbles per cycle (A1..A(ADDR_NIB)); must be 3 for the I4004
- CM_CH, 4, number of CM-RAM select lines
- DEPTH, 8, response FIFO entries (≥2)

Ports (one clock, `sysclk`; reset `reset_n`, asynchronous, active-low):
- sysclk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- clk2_pad  in  1  CPU phase clock, sampled by sysclk
- poc_pad  in  1  power-on clear; 1 forces bus release and IDLE
- sync_pad  in  1  CPU SYNC, marks X3
- cmrom_pad  in  1  ROM select
- cmram_pad  in  CM_CH  RAM bank selects
- data_in  in  DW  sampled data pads
- data_out  out  DW  drive value
- data_oe  out  1  pad output enable
- rsp_valid  in  1  push request
- rsp_ready  out  1  FIFO not full
- rsp_data  in  2*DW  {OPR, OPA}
- fifo_count  out  $clog2(DEPTH+1)  occupancy
- addr_valid  out  1  one-cycle pulse, address complete
- addr_out  out  ADDR_NIB*DW  captured address, nibble 0 = A1
- cm_sel  out  CM_CH+1  {cmram_pad, cmrom_pad} sampled at A3
- x2_valid  out  1  one-cycle pulse, X2 data captured
- x2_data  out  DW  data sampled in X2
- cycle_err  out  1  sticky protocol error
- underrun  out  1  sticky FIFO empty on ROM fetch

## Operation
- Phase strobe: `stb = clk2_pad & ~clk2_q`, where `clk2_q` is the registered previous `clk2_pad`. The FSM advances only on `stb`.
- FSM states: IDLE, A1, A2, A3, M1, M2, X1, X2, X3.
  - IDLE → A1 on `stb & sync_pad`.
  - Otherwise the phases advance sequentially on `stb`.
  - X3 → A1 if `sync_pad` is 1 at the strobe. If not, set `cycle_err` and go to IDLE.
  - `sync_pad` = 1 at a strobe while in any phase other than X3/IDLE: set `cycle_err`, resync to A1.
- A-phases: on the strobe leaving Ak, capture `data_in` into nibble k-1 of `addr_out`.
- Leaving A3:
  - `addr_valid` = 1 for one cycle.
  - Latch `cm_sel`.
  - Latch `rom_hit` = `cmrom_pad`.
- M1/M2 (only if `rom_hit`):
  - `data_oe` = 1 for the whole of M1 and M2.
  - `data_out` = OPR (`rsp_data[2*DW-1:DW]`) in M1, OPA (`rsp_data[DW-1:0]`) in M2, both taken from the FIFO head.
  - On the strobe leaving M2, pop the head.
- FIFO empty at entry to M1 with `rom_hit`: drive 0 for both nibbles, set `underrun`, no pop.
- `rom_hit` = 0: `data_oe` stays 0, no pop.
- X-phases: `data_oe` = 0. On the strobe leaving X2, capture `data_in` into `x2_data` and pulse `x2_valid`.
- FIFO:
  - Push on `rsp_valid & rsp_ready`.
  - `rsp_ready` = (`fifo_count` < DEPTH).
  - Simultaneous push and pop: `fifo_count` unchanged.
  - Pointers wrap modulo DEPTH.
- `poc_pad` = 1:
  - Synchronously forces IDLE and `data_oe` = 0.
  - FIFO contents and sticky flags are kept.
- Sticky flags clear only on reset.

## Timing
- Reset values: all outputs 0, except `rsp_ready` = 1. FSM in IDLE, FIFO empty, `clk2_q` = 0.
- Reset asserted mid-cycle: immediate return to reset values; the FIFO is flushed.
- `data_oe`/`data_out` are registered. They change 1 sysclk cycle after the `stb` that enters M1, and fall 1 cycle after the `stb` that leaves M2.
- `addr_valid`, `x2_valid` and the pop occur in the cycle after the corresponding strobe.
- Push-to-available latency: 1 cycle. An entry pushed in the same cycle as entry to M1 is not seen by that M1.

## Configuration
- `I4004_AGENT_MON_EN` defined:
  - X2 monitor is present.
  - `x2_data`/`x2_valid` operate as above.
- Not defined:
  - `x2_data` = 0 and `x2_valid` = 0 constantly.
  - The capture register is not built.
  - FSM and drive behaviour are unchanged.

## Test plan
- Reset, push {0xD,0x5}, SYNC then A1–A3 data 0x2,0x1,0x0 with `cmrom_pad`=1 at A3:
  - `addr_out` = 0x012, `addr_valid` pulses.
  - `data_out` = 0xD in M1, 0x5 in M2, `data_oe` = 1 only in M1–M2.
  - `fifo_count` goes 1 → 0.
- Push DEPTH entries, then one more:
  - `rsp_ready` = 0, `fifo_count` = DEPTH, extra entry dropped.
  - One fetch, then push in the pop cycle: count stays DEPTH-1 → DEPTH.
- ROM fetch with an empty FIFO:
  - `data_out` = 0 in M1/M2, `underrun` = 1 and stays 1.
  - `fifo_count` remains 0.
- SYNC missing at the X3 strobe:
  - `cycle_err` = 1, FSM in IDLE, `data_oe` = 0.
  - Next SYNC restarts at A1.
- `poc_pad` = 1 during M1:
  - `data_oe` = 0 the next cycle, FSM in IDLE.
  - FIFO count unchanged. `reset_n` low during M2 clears all outputs and the FIFO.
- X2 data 0xA with `I4004_AGENT_MON_EN` defined:
  - `x2_data` = 0xA, `x2_valid` pulses once.
  - Without the macro: both remain 0.
